regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard, write-to-read bypass
// and a sequential clear engine that zeroes every entry after reset.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  output logic                     Ready,
  input  logic [NUM_RD*ADDR_W-1:0] RAddr,
  output logic [NUM_RD*DATA_W-1:0] RData,
  output logic [NUM_RD-1:0]        RBusy,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WAddr,
  input  logic [DATA_W-1:0]        WData,
  input  logic                     Alloc,
  input  logic [ADDR_W-1:0]        AllocAddr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clrIdx_q, clrIdx_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                memWe;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memData;
  logic [ADDR_W-1:0]   rdAddr;

  // The storage write port is shared between the clear engine and writeback.
  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    busy_d   = busy_q;
    memWe    = 1'b0;
    memAddr  = WAddr;
    memData  = WData;
    case (state_q)
      CLEAR: begin
        memWe    = 1'b1;
        memAddr  = clrIdx_q;
        memData  = '0;
        clrIdx_d = clrIdx_q + 1'b1;
        if (clrIdx_q == LAST_IDX) begin
          state_d  = READY;
          clrIdx_d = '0;
        end
      end
      READY: begin
        if (WE && (WAddr != '0)) begin
          memWe         = 1'b1;
          busy_d[WAddr] = 1'b0;
        end
        // Applied after the write so a same-cycle allocation keeps the flag set.
        if (Alloc && (AllocAddr != '0)) begin
          busy_d[AllocAddr] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= CLEAR;
      clrIdx_q <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset && memWe) begin
      mem_q[memAddr] <= memData;
    end
  end

  assign Ready = (state_q == READY);

  always_comb begin
    RData  = '0;
    RBusy  = '0;
    rdAddr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rdAddr = RAddr[k*ADDR_W +: ADDR_W];
      if ((state_q == READY) && (rdAddr != '0)) begin
        if ((BYPASS != 0) && WE && (WAddr == rdAddr)) begin
          // The in-flight write clears the busy flag, so forwarded data is never busy.
          RData[k*DATA_W +: DATA_W] = WData;
          RBusy[k]                  = 1'b0;
        end else begin
          RData[k*DATA_W +: DATA_W] = mem_q[rdAddr];
          RBusy[k]                  = busy_q[rdAddr];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 3-port bypassing instance and a 1-port
// non-bypassing instance share clock, reset and write/alloc stimulus.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          alloc = 1'b0;
  logic [AW-1:0] allocAddr = '0;
  logic [3*AW-1:0] raddr = '0;

  logic          readyA, readyB;
  logic [3*DW-1:0] rdataA;
  logic [2:0]    rbusyA;
  logic [DW-1:0] rdataB;
  logic          rbusyB;

  int vectors = 0;
  int miscompares = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(3), .BYPASS(1)) dutA (
    .CLK(clk), .Reset(reset), .Ready(readyA),
    .RAddr(raddr), .RData(rdataA), .RBusy(rbusyA),
    .WE(we), .WAddr(waddr), .WData(wdata),
    .Alloc(alloc), .AllocAddr(allocAddr)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(1), .BYPASS(0)) dutB (
    .CLK(clk), .Reset(reset), .Ready(readyB),
    .RAddr(raddr[AW-1:0]), .RData(rdataB), .RBusy(rbusyB),
    .WE(we), .WAddr(waddr), .WData(wdata),
    .Alloc(alloc), .AllocAddr(allocAddr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr = {AW'(i), AW'(31 - i), AW'(i)};
      #1;
      vectors++;
      if (readyA !== 1'b0 || readyB !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ready_during_clear cycle %0d: got A=%b B=%b expected 0", i, readyA, readyB);
      end
      vectors++;
      if (rdataA !== '0 || rdataB !== '0 || rbusyA !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL data_during_clear cycle %0d: got A=%h B=%h busy=%b expected 0", i, rdataA, rdataB, rbusyA);
      end
      step();
    end
    vectors++;
    if (readyA !== 1'b1 || readyB !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_clear: got A=%b B=%b expected 1", readyA, readyB);
    end
    for (int i = 0; i < 32; i++) begin
      raddr = {AW'(i), AW'(i), AW'(i)};
      #1;
      vectors++;
      if (rdataA !== '0 || rdataB !== '0) begin
        miscompares++;
        $display("[TB] FAIL cleared_read r%0d: got A=%h B=%h expected 0", i, rdataA, rdataB);
      end
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'h1111_1111;
    step();
    wdata = 32'hDEAD_BEEF;
    raddr = {5'd0, 5'd0, 5'd5};
    #1;
    vectors++;
    if (rdataA[31:0] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected deadbeef", rdataA[31:0]);
    end
    vectors++;
    if (rdataB !== 32'h1111_1111) begin
      miscompares++;
      $display("[TB] FAIL nobypass_same_cycle: got %h expected 11111111", rdataB);
    end
    step();
    we = 1'b0;
    #1;
    vectors++;
    if (rdataA[31:0] !== 32'hDEAD_BEEF || rdataB !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL write_next_cycle: got A=%h B=%h expected deadbeef", rdataA[31:0], rdataB);
    end
  endtask

  task automatic test_busy();
    alloc = 1'b1; allocAddr = 5'd7;
    raddr = {5'd7, 5'd7, 5'd7};
    #1;
    vectors++;
    if (rbusyA !== 3'b000 || rbusyB !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alloc_same_cycle: got A=%b B=%b expected 000/0", rbusyA, rbusyB);
    end
    step();
    alloc = 1'b0;
    #1;
    vectors++;
    if (rbusyA !== 3'b111 || rbusyB !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL alloc_next_cycle: got A=%b B=%b expected 111/1", rbusyA, rbusyB);
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_1234;
    #1;
    vectors++;
    if (rbusyA !== 3'b000 || rdataA[31:0] !== 32'h0000_1234) begin
      miscompares++;
      $display("[TB] FAIL busy_bypass_clear: got busy=%b data=%h expected 000/00001234", rbusyA, rdataA[31:0]);
    end
    vectors++;
    if (rbusyB !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_nobypass_hold: got %b expected 1", rbusyB);
    end
    step();
    we = 1'b0;
    #1;
    vectors++;
    if (rbusyA !== 3'b000 || rbusyB !== 1'b0 || rdataB !== 32'h0000_1234) begin
      miscompares++;
      $display("[TB] FAIL busy_after_write: got A=%b B=%b data=%h expected 000/0/00001234", rbusyA, rbusyB, rdataB);
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_5678;
    alloc = 1'b1; allocAddr = 5'd7;
    step();
    we = 1'b0; alloc = 1'b0;
    #1;
    vectors++;
    if (rbusyA !== 3'b111 || rbusyB !== 1'b1 || rdataA[31:0] !== 32'h0000_5678) begin
      miscompares++;
      $display("[TB] FAIL alloc_wins: got busy=%b/%b data=%h expected 111/1/00005678", rbusyA, rbusyB, rdataA[31:0]);
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_5678;
    step();
    we = 1'b0;
  endtask

  task automatic test_reg0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    alloc = 1'b1; allocAddr = 5'd0;
    raddr = '0;
    #1;
    vectors++;
    if (rdataA !== '0 || rbusyA !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL r0_same_cycle: got data=%h busy=%b expected 0", rdataA, rbusyA);
    end
    step();
    we = 1'b0; alloc = 1'b0;
    #1;
    vectors++;
    if (rdataA !== '0 || rbusyA !== 3'b000 || rdataB !== '0 || rbusyB !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL r0_after: got A=%h/%b B=%h/%b expected 0", rdataA, rbusyA, rdataB, rbusyB);
    end
  endtask

  task automatic test_multiport();
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5_A5A5;
    step();
    we = 1'b0;
    raddr = {5'd9, 5'd9, 5'd9};
    #1;
    vectors++;
    if (rdataA !== {3{32'hA5A5_A5A5}}) begin
      miscompares++;
      $display("[TB] FAIL multiport_same: got %h expected a5a5a5a5 x3", rdataA);
    end
    raddr = {5'd9, 5'd7, 5'd5};
    #1;
    vectors++;
    if (rdataA !== {32'hA5A5_A5A5, 32'h0000_5678, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL multiport_distinct: got %h expected a5a5a5a5_00005678_deadbeef", rdataA);
    end
  endtask

  task automatic test_reset_midclear();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    // Hold a write and an alloc to r3 for the whole clear; both must be dropped.
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D;
    alloc = 1'b1; allocAddr = 5'd3;
    raddr = {5'd3, 5'd3, 5'd3};
    for (int i = 0; i < 32; i++) begin
      #1;
      vectors++;
      if (readyA !== 1'b0 || rdataA !== '0 || rbusyA !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL reclear cycle %0d: got ready=%b data=%h busy=%b expected 0", i, readyA, rdataA, rbusyA);
      end
      step();
    end
    we = 1'b0; alloc = 1'b0;
    #1;
    vectors++;
    if (readyA !== 1'b1 || readyB !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reclear_ready: got A=%b B=%b expected 1", readyA, readyB);
    end
    vectors++;
    if (rdataA !== '0 || rbusyA !== 3'b000 || rdataB !== '0) begin
      miscompares++;
      $display("[TB] FAIL clear_write_dropped: got %h busy=%b B=%h expected 0", rdataA, rbusyA, rdataB);
    end
    raddr = {5'd9, 5'd7, 5'd5};
    #1;
    vectors++;
    if (rdataA !== '0 || rdataB !== '0) begin
      miscompares++;
      $display("[TB] FAIL old_data_cleared: got A=%h B=%h expected 0", rdataA, rdataB);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_busy();
    test_reg0();
    test_multiport();
    test_reset_midclear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
